// File: rtl/sr_ff_bank.sv
// WIDTH-channel synchronous SR storage bank with active-low set/reset inputs and invalid-input logging.
// Optional macro SR_INPUT_SYNC_EN inserts a 2-flop synchronizer on s_n/r_n ahead of the decode.
module sr_ff_bank #(
   parameter int               WIDTH        = 4,
   parameter int               INVALID_MODE = 0,
   parameter logic [WIDTH-1:0] RESET_VAL    = '0,
   parameter int               CNT_W        = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] s_n,
   input  logic [WIDTH-1:0] r_n,
   input  logic             clr_err,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qbar,
   output logic [WIDTH-1:0] err_sticky,
   output logic [CNT_W-1:0] err_cnt,
   output logic             err_pulse
);

   // Out-of-range modes fall back to hold.
   localparam int               MODE    = (INVALID_MODE >= 0 && INVALID_MODE <= 3) ? INVALID_MODE : 0;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [WIDTH-1:0] s_dec;
   logic [WIDTH-1:0] r_dec;

`ifdef SR_INPUT_SYNC_EN
   logic [WIDTH-1:0] s_meta_q;
   logic [WIDTH-1:0] s_sync_q;
   logic [WIDTH-1:0] r_meta_q;
   logic [WIDTH-1:0] r_sync_q;

   // Synchronizer flops idle at 1 so a reset flushes any in-flight request.
   always_ff @(posedge clk) begin
      if (rst) begin
         s_meta_q <= '1;
         s_sync_q <= '1;
         r_meta_q <= '1;
         r_sync_q <= '1;
      end else begin
         s_meta_q <= s_n;
         s_sync_q <= s_meta_q;
         r_meta_q <= r_n;
         r_sync_q <= r_meta_q;
      end
   end

   assign s_dec = s_sync_q;
   assign r_dec = r_sync_q;
`else
   assign s_dec = s_n;
   assign r_dec = r_n;
`endif

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;
   logic [WIDTH-1:0] sticky_q;
   logic [WIDTH-1:0] sticky_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             pulse_q;
   logic [WIDTH-1:0] inv_vec;
   logic             inv;

   assign inv_vec = ~s_dec & ~r_dec;
   assign inv     = |inv_vec;

   always_comb begin
      q_d = q_q;
      for (int i = 0; i < WIDTH; i++) begin
         case ({s_dec[i], r_dec[i]})
            2'b01:   q_d[i] = 1'b1;
            2'b10:   q_d[i] = 1'b0;
            2'b00: begin
               case (MODE)
                  1:       q_d[i] = 1'b1;
                  2:       q_d[i] = 1'b0;
                  3:       q_d[i] = ~q_q[i];
                  default: q_d[i] = q_q[i];
               endcase
            end
            default: q_d[i] = q_q[i];
         endcase
      end
   end

   // A clear in the same cycle as an invalid input keeps only the new event.
   always_comb begin
      sticky_d = sticky_q | inv_vec;
      cnt_d    = cnt_q;
      if (clr_err) begin
         sticky_d = inv_vec;
         cnt_d    = inv ? CNT_W'(1) : '0;
      end else if (inv && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_q      <= RESET_VAL;
         sticky_q <= '0;
         cnt_q    <= '0;
         pulse_q  <= 1'b0;
      end else begin
         q_q      <= q_d;
         sticky_q <= sticky_d;
         cnt_q    <= cnt_d;
         pulse_q  <= inv;
      end
   end

   assign q          = q_q;
   assign qbar       = ~q_q;
   assign err_sticky = sticky_q;
   assign err_cnt    = cnt_q;
   assign err_pulse  = pulse_q;

endmodule

// File: tb/tb_sr_ff_bank.sv
// Bench for sr_ff_bank: four INVALID_MODE variants plus a CNT_W=2 / RESET_VAL=4'hA variant share stimulus,
// with a per-cycle scoreboard and directed checks. Honours SR_INPUT_SYNC_EN for the 3-cycle latency.
module tb_sr_ff_bank;

`ifdef SR_INPUT_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif
   localparam int ND = 5;

   typedef struct packed {
      logic [ND-1:0][3:0] q;
      logic [ND-1:0][3:0] st;
      logic [ND-1:0][7:0] cnt;
      logic [ND-1:0]      pl;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] s_n = 4'hF;
   logic [3:0] r_n = 4'hF;
   logic       clr_err = 1'b0;

   logic [3:0] q_w  [ND];
   logic [3:0] qb_w [ND];
   logic [3:0] st_w [ND];
   logic       pl_w [ND];
   logic [7:0] cnt8 [4];
   logic [1:0] cnt4;

   int total = 0;
   int bad   = 0;

   exp_t sbq[$];

   int         mode_of [ND] = '{0, 1, 2, 3, 0};
   int         cmax    [ND] = '{255, 255, 255, 255, 3};
   logic [3:0] rval    [ND] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'hA};
   logic [3:0] m_q     [ND];
   logic [3:0] m_st    [ND];
   int         m_cnt   [ND];
   logic       m_pl    [ND];
   logic [3:0] d1_s = 4'hF, d2_s = 4'hF, d1_r = 4'hF, d2_r = 4'hF;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      sr_ff_bank #(.WIDTH(4), .INVALID_MODE(g), .RESET_VAL(4'h0), .CNT_W(8)) u_dut (
         .clk(clk), .rst(rst), .s_n(s_n), .r_n(r_n), .clr_err(clr_err),
         .q(q_w[g]), .qbar(qb_w[g]), .err_sticky(st_w[g]), .err_cnt(cnt8[g]), .err_pulse(pl_w[g]));
   end

   sr_ff_bank #(.WIDTH(4), .INVALID_MODE(0), .RESET_VAL(4'hA), .CNT_W(2)) u_sat (
      .clk(clk), .rst(rst), .s_n(s_n), .r_n(r_n), .clr_err(clr_err),
      .q(q_w[4]), .qbar(qb_w[4]), .err_sticky(st_w[4]), .err_cnt(cnt4), .err_pulse(pl_w[4]));

   function automatic logic [7:0] dut_cnt(input int k);
      logic [1:0] idx;
      idx = k[1:0];
      if (k == 4) return {6'b0, cnt4};
      return cnt8[idx];
   endfunction

   // Drive one cycle of stimulus and queue what every instance must show after the next edge.
   task automatic step(input logic r, input logic [3:0] s, input logic [3:0] rr, input logic c);
      logic [3:0] es, er, iv, nq;
      exp_t e;
      @(negedge clk); #1;
      rst = r; s_n = s; r_n = rr; clr_err = c;
      if (LAT == 3) begin
         es = d2_s; er = d2_r;
         if (r) begin
            d1_s = 4'hF; d2_s = 4'hF; d1_r = 4'hF; d2_r = 4'hF;
         end else begin
            d2_s = d1_s; d1_s = s; d2_r = d1_r; d1_r = rr;
         end
      end else begin
         es = s; er = rr;
      end
      iv = ~es & ~er;
      for (int k = 0; k < ND; k++) begin
         if (r) begin
            m_q[k] = rval[k]; m_st[k] = 4'h0; m_cnt[k] = 0; m_pl[k] = 1'b0;
         end else begin
            nq = m_q[k];
            for (int i = 0; i < 4; i++) begin
               if (!es[i] && er[i])       nq[i] = 1'b1;
               else if (es[i] && !er[i])  nq[i] = 1'b0;
               else if (!es[i] && !er[i]) begin
                  if (mode_of[k] == 1)      nq[i] = 1'b1;
                  else if (mode_of[k] == 2) nq[i] = 1'b0;
                  else if (mode_of[k] == 3) nq[i] = ~m_q[k][i];
               end
            end
            m_q[k]  = nq;
            m_pl[k] = (iv != 4'h0);
            if (c) begin
               m_st[k]  = iv;
               m_cnt[k] = (iv != 4'h0) ? 1 : 0;
            end else begin
               m_st[k] = m_st[k] | iv;
               if (iv != 4'h0 && m_cnt[k] < cmax[k]) m_cnt[k] = m_cnt[k] + 1;
            end
         end
         e.q[k] = m_q[k]; e.st[k] = m_st[k]; e.cnt[k] = 8'(m_cnt[k]); e.pl[k] = m_pl[k];
      end
      sbq.push_back(e);
   endtask

   task automatic hold_lat();
      repeat (LAT - 1) step(1'b0, 4'hF, 4'hF, 1'b0);
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         for (int k = 0; k < ND; k++) begin
            total++;
            if (q_w[k] !== e.q[k]) begin
               bad++; $display("FAIL sb_q dut%0d: got %h want %h", k, q_w[k], e.q[k]);
            end
            total++;
            if (qb_w[k] !== ~e.q[k]) begin
               bad++; $display("FAIL sb_qbar dut%0d: got %h want %h", k, qb_w[k], ~e.q[k]);
            end
            total++;
            if (st_w[k] !== e.st[k]) begin
               bad++; $display("FAIL sb_sticky dut%0d: got %h want %h", k, st_w[k], e.st[k]);
            end
            total++;
            if (dut_cnt(k) !== e.cnt[k]) begin
               bad++; $display("FAIL sb_cnt dut%0d: got %0d want %0d", k, dut_cnt(k), e.cnt[k]);
            end
            total++;
            if (pl_w[k] !== e.pl[k]) begin
               bad++; $display("FAIL sb_pulse dut%0d: got %b want %b", k, pl_w[k], e.pl[k]);
            end
         end
      end
   end

   task automatic test_reset();
      step(1'b1, 4'hF, 4'hF, 1'b0);
      @(posedge clk); #1;
      total++;
      if (q_w[0] !== 4'h0)  begin bad++; $display("FAIL reset_q: got %h want 0", q_w[0]); end
      total++;
      if (qb_w[0] !== 4'hF) begin bad++; $display("FAIL reset_qbar: got %h want f", qb_w[0]); end
      total++;
      if (cnt8[0] !== 8'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", cnt8[0]); end
      total++;
      if (pl_w[0] !== 1'b0) begin bad++; $display("FAIL reset_pulse: got %b want 0", pl_w[0]); end
      total++;
      if (q_w[4] !== 4'hA)  begin bad++; $display("FAIL reset_val: got %h want a", q_w[4]); end
   endtask

   task automatic test_set_hold_reset();
      step(1'b0, 4'hE, 4'hF, 1'b0); hold_lat();
      @(posedge clk); #1;
      total++;
      if (q_w[0] !== 4'h1) begin bad++; $display("FAIL set_q: got %h want 1", q_w[0]); end
      step(1'b0, 4'hF, 4'hF, 1'b0); hold_lat();
      @(posedge clk); #1;
      total++;
      if (q_w[0] !== 4'h1) begin bad++; $display("FAIL hold_q: got %h want 1", q_w[0]); end
      step(1'b0, 4'hF, 4'hE, 1'b0); hold_lat();
      @(posedge clk); #1;
      total++;
      if (q_w[0] !== 4'h0) begin bad++; $display("FAIL clear_q: got %h want 0", q_w[0]); end
   endtask

   task automatic test_invalid();
      step(1'b0, 4'hB, 4'hF, 1'b0); hold_lat();
      step(1'b0, 4'hB, 4'hB, 1'b0); hold_lat();
      @(posedge clk); #1;
      total++;
      if (q_w[0] !== 4'h4)  begin bad++; $display("FAIL inv_q: got %h want 4", q_w[0]); end
      total++;
      if (pl_w[0] !== 1'b1) begin bad++; $display("FAIL inv_pulse: got %b want 1", pl_w[0]); end
      total++;
      if (st_w[0] !== 4'h4) begin bad++; $display("FAIL inv_sticky: got %h want 4", st_w[0]); end
      total++;
      if (cnt8[0] !== 8'd1) begin bad++; $display("FAIL inv_cnt: got %0d want 1", cnt8[0]); end
      step(1'b0, 4'hF, 4'hF, 1'b0);
      @(posedge clk); #1;
      total++;
      if (pl_w[0] !== 1'b0) begin bad++; $display("FAIL inv_pulse_end: got %b want 0", pl_w[0]); end
   endtask

   task automatic test_modes();
      step(1'b1, 4'hF, 4'hF, 1'b0);
      step(1'b0, 4'hB, 4'hB, 1'b0); hold_lat();
      @(posedge clk); #1;
      total++;
      if (q_w[1] !== 4'h4) begin bad++; $display("FAIL mode1_q: got %h want 4", q_w[1]); end
      total++;
      if (q_w[2] !== 4'h0) begin bad++; $display("FAIL mode2_q: got %h want 0", q_w[2]); end
      total++;
      if (q_w[3] !== 4'h4) begin bad++; $display("FAIL mode3_q: got %h want 4", q_w[3]); end
      step(1'b0, 4'hB, 4'hB, 1'b0); hold_lat();
      @(posedge clk); #1;
      total++;
      if (q_w[3] !== 4'h0) begin bad++; $display("FAIL mode3_toggle: got %h want 0", q_w[3]); end
   endtask

   task automatic test_saturation();
      step(1'b1, 4'hF, 4'hF, 1'b0);
      repeat (5) step(1'b0, 4'hB, 4'hB, 1'b0);
      hold_lat();
      @(posedge clk); #1;
      total++;
      if (cnt4 !== 2'd3) begin bad++; $display("FAIL sat_cnt: got %0d want 3", cnt4); end
      step(1'b0, 4'hF, 4'hF, 1'b1); hold_lat();
      @(posedge clk); #1;
      total++;
      if (cnt4 !== 2'd0)    begin bad++; $display("FAIL clr_cnt: got %0d want 0", cnt4); end
      total++;
      if (st_w[4] !== 4'h0) begin bad++; $display("FAIL clr_sticky: got %h want 0", st_w[4]); end
      step(1'b0, 4'hD, 4'hD, 1'b1); hold_lat();
      @(posedge clk); #1;
      total++;
      if (cnt4 !== 2'd1)    begin bad++; $display("FAIL clrinv_cnt: got %0d want 1", cnt4); end
      total++;
      if (st_w[4] !== 4'h2) begin bad++; $display("FAIL clrinv_sticky: got %h want 2", st_w[4]); end
   endtask

   task automatic test_reset_mid();
      step(1'b1, 4'hF, 4'hF, 1'b0);
      step(1'b0, 4'hE, 4'hF, 1'b0);
      step(1'b1, 4'hF, 4'hF, 1'b0);
      step(1'b0, 4'hF, 4'hF, 1'b0);
      step(1'b0, 4'hF, 4'hF, 1'b0);
      @(posedge clk); #1;
      total++;
      if (q_w[0] !== 4'h0) begin bad++; $display("FAIL rstmid_q: got %h want 0", q_w[0]); end
      total++;
      if (q_w[4] !== 4'hA) begin bad++; $display("FAIL rstmid_rval: got %h want a", q_w[4]); end
   endtask

   task automatic test_back_to_back();
      logic [3:0] s, r;
      for (int n = 0; n < 60; n++) begin
         s = 4'($urandom_range(0, 15));
         r = 4'($urandom_range(0, 15));
         step(($urandom_range(0, 19) == 0), s, r, ($urandom_range(0, 7) == 0));
      end
      step(1'b0, 4'hF, 4'hF, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_set_hold_reset();
      test_invalid();
      test_modes();
      test_saturation();
      test_reset_mid();
      test_back_to_back();
      repeat (2) @(posedge clk);
      #2;
      total++;
      if (sbq.size() != 0) begin
         bad++; $display("FAIL sb_drain: got %0d pending want 0", sbq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
